// File: rtl/character_transmission.sv
// Transmit half of the uart_lite character path: valid/ready character input,
// one-entry holding register, and an oversampled async frame serialiser on tx_o.
module character_transmission #(
    parameter int unsigned OVERSAMPLING = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] char_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLING);
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OVERSAMPLING - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic PAR_ODD    = 1'(PARITY % 2);
    localparam bit   HAS_PARITY = (PARITY != 0);
    localparam bit   TWO_STOP   = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic                 par_q, par_d;
    logic                 hold_empty_q, hold_empty_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;

    logic accept;
    logic bit_end;
    logic last_stop_bit;
    logic shifter_free;
    logic load;

    // Next-state, datapath and output decode
    always_comb begin
        accept        = valid_i && hold_empty_q;
        bit_end       = (cnt_q == '0);
        last_stop_bit = TWO_STOP ? stop_q : 1'b1;
        shifter_free  = (state_q == S_IDLE) ||
                        ((state_q == S_STOP) && last_stop_bit && bit_end);

        state_d      = state_q;
        cnt_d        = (state_q == S_IDLE) ? cnt_q : cnt_q - CNT_W'(1);
        idx_d        = idx_q;
        stop_d       = stop_q;
        par_d        = par_q;
        hold_empty_d = hold_empty_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        load         = 1'b0;
        tx_d         = 1'b1;
        busy_d       = 1'b0;

        case (state_q)
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    cnt_d   = CNT_MAX;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = CNT_MAX;
                    if (idx_q == IDX_LAST) begin
                        state_d = HAS_PARITY ? S_PARITY : S_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                    cnt_d   = CNT_MAX;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (last_stop_bit) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        stop_d = 1'b1;
                        cnt_d  = CNT_MAX;
                    end
                end
            end
            default: ;
        endcase

        // A held character always wins the free shifter; ready_o is low then
        if (shifter_free && !hold_empty_q) begin
            shift_d      = hold_q;
            hold_empty_d = 1'b1;
            load         = 1'b1;
        end else if (shifter_free && accept) begin
            shift_d = char_i;
            load    = 1'b1;
        end else if (accept) begin
            hold_d       = char_i;
            hold_empty_d = 1'b0;
        end

        if (load) begin
            state_d = S_START;
            cnt_d   = CNT_MAX;
            par_d   = (^shift_d) ^ PAR_ODD;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[idx_d];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE) || !hold_empty_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            stop_q       <= 1'b0;
            par_q        <= 1'b0;
            hold_empty_q <= 1'b1;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stop_q       <= stop_d;
            par_q        <= par_d;
            hold_empty_q <= hold_empty_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
        end
    end

    // Character storage carries no reset; it is qualified by state and hold_empty_q
    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
        hold_q  <= hold_d;
    end

    assign ready_o = hold_empty_q;
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_character_transmission.sv
// Bench for character_transmission: two configurations checked every cycle
// against a frame-offset reference model under directed and random traffic.
module tb_character_transmission;

    localparam int OS_A = 16, DB_A = 8, PAR_A = 2, ST_A = 2;
    localparam int OS_B = 3,  DB_B = 5, PAR_B = 1, ST_B = 1;
    localparam int F_A = OS_A * (1 + DB_A + ((PAR_A != 0) ? 1 : 0) + ST_A);
    localparam int F_B = OS_B * (1 + DB_B + ((PAR_B != 0) ? 1 : 0) + ST_B);

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic [7:0] char_i;
    logic [4:0] char_b;
    logic       ready_a, tx_a, busy_a;
    logic       ready_b, tx_b, busy_b;

    assign char_b = char_i[4:0];

    always #5 clk_i = ~clk_i;

    character_transmission #(
        .OVERSAMPLING(OS_A), .DATA_BITS(DB_A), .PARITY(PAR_A), .STOP_BITS(ST_A)
    ) u_dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .char_i(char_i), .valid_i(valid_i),
        .ready_o(ready_a), .tx_o(tx_a), .busy_o(busy_a)
    );

    character_transmission #(
        .OVERSAMPLING(OS_B), .DATA_BITS(DB_B), .PARITY(PAR_B), .STOP_BITS(ST_B)
    ) u_dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .char_i(char_b), .valid_i(valid_i),
        .ready_o(ready_b), .tx_o(tx_b), .busy_o(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    bit         m_active[2];
    int         m_start[2];
    logic [7:0] m_ch[2];
    bit         m_held[2];
    logic [7:0] m_hch[2];

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at edge %0d", tag, got, exp, edge_n);
        end
    endtask

    // Line level for bit period k/os of a frame: start, data LSB first, parity, stops
    function automatic logic frame_bit(input int os, input int db, input int par,
                                       input logic [7:0] ch, input int k);
        int   b;
        logic p;
        b = k / os;
        if (b == 0) return 1'b0;
        if (b <= db) return ch[b-1];
        if (par != 0 && b == db + 1) begin
            p = (par % 2 == 1);
            for (int i = 0; i < db; i++) p = p ^ ch[i];
            return p;
        end
        return 1'b1;
    endfunction

    function automatic logic exp_tx(input int i);
        if (!m_active[i]) return 1'b1;
        if (i == 0) return frame_bit(OS_A, DB_A, PAR_A, m_ch[0], edge_n - m_start[0]);
        return frame_bit(OS_B, DB_B, PAR_B, m_ch[1], edge_n - m_start[1]);
    endfunction

    task automatic model_edge();
        bit         free, acc;
        int         flen;
        logic [7:0] c;
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            if (rst_i) begin
                m_active[i] = 1'b0;
                m_held[i]   = 1'b0;
            end else begin
                flen = (i == 0) ? F_A : F_B;
                c    = (i == 0) ? char_i : {3'b000, char_i[4:0]};
                free = !m_active[i] || (edge_n - m_start[i] == flen);
                acc  = valid_i && !m_held[i];
                if (free && m_held[i]) begin
                    m_start[i]  = edge_n;
                    m_ch[i]     = m_hch[i];
                    m_held[i]   = 1'b0;
                    m_active[i] = 1'b1;
                end else if (free && acc) begin
                    m_start[i]  = edge_n;
                    m_ch[i]     = c;
                    m_active[i] = 1'b1;
                end else if (free) begin
                    m_active[i] = 1'b0;
                end else if (acc) begin
                    m_held[i] = 1'b1;
                    m_hch[i]  = c;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        check("tx_a",    tx_a,    exp_tx(0));
        check("ready_a", ready_a, !m_held[0]);
        check("busy_a",  busy_a,  m_active[0] || m_held[0]);
        check("tx_b",    tx_b,    exp_tx(1));
        check("ready_b", ready_b, !m_held[1]);
        check("busy_b",  busy_b,  m_active[1] || m_held[1]);
    endtask

    task automatic send(input logic [7:0] c);
        valid_i = 1'b1;
        char_i  = c;
        step();
        valid_i = 1'b0;
        char_i  = 8'($urandom);
    endtask

    initial begin
        int thr;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        char_i  = 8'h00;
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_held[i]   = 1'b0;
            m_start[i]  = 0;
            m_ch[i]     = 8'h00;
            m_hch[i]    = 8'h00;
        end
        repeat (3) step();
        rst_i = 1'b0;
        repeat (5) step();

        // Single frames, including parity cases
        send(8'h55); repeat (250) step();
        send(8'h01); repeat (250) step();
        send(8'h07); repeat (250) step();
        send(8'h03); repeat (250) step();

        // valid_i held high across two accepts: back-to-back frames
        valid_i = 1'b1; char_i = 8'hA5; step();
        char_i = 8'h3C; step();
        valid_i = 1'b0;
        repeat (450) step();

        // Reset partway through a frame with a character held
        valid_i = 1'b1; char_i = 8'h5A; step();
        char_i = 8'hC3; step();
        valid_i = 1'b0;
        repeat (38) step();
        rst_i = 1'b1; step();
        rst_i = 1'b0;
        repeat (250) step();

        // Random traffic with varying offered load and rare resets
        for (int blk = 0; blk < 45; blk++) begin
            case ($urandom_range(0, 2))
                0:       thr = 2;
                1:       thr = 40;
                default: thr = 256;
            endcase
            repeat (1000) begin
                valid_i = (int'($urandom_range(0, 255)) < thr);
                char_i  = 8'($urandom);
                rst_i   = ($urandom_range(0, 4999) == 0);
                step();
            end
        end
        rst_i   = 1'b0;
        valid_i = 1'b0;
        repeat (300) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
